// File: rtl/proc_ctrl_fsm_pkg.sv
// Shared definitions for the lab processor control unit.
//  - Opcode values for mv / mvi / add / sub.
//  - Time-step state type T0..T3.
//  - Field extractors for instruction words of the form IIXXXYYY.
package proc_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam int unsigned OPC_HI = 7;
  localparam int unsigned OPC_LO = 6;
  localparam int unsigned RX_HI  = 5;
  localparam int unsigned RX_LO  = 3;
  localparam int unsigned RY_HI  = 2;
  localparam int unsigned RY_LO  = 0;

  function automatic logic [1:0] opc_of(input logic [7:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [2:0] rx_of(input logic [7:0] w);
    return w[RX_HI:RX_LO];
  endfunction

  function automatic logic [2:0] ry_of(input logic [7:0] w);
    return w[RY_HI:RY_LO];
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_reg_onehot_dec.sv
// 3-to-8 register-select decoder.
//  sel    in  3  register index; bit i of onehot corresponds to Ri
//  en     in  1  when low the output is all zeros
//  onehot out 8  one-hot register select
module reg_onehot_dec (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Control unit for the 8-register, single-bus lab processor.
// Latches IIXXXYYY instruction words, steps T0..T3 and decodes the bus
// selects and load enables for mv / mvi / add / sub.
//  P_clock in   1   clock, rising edge
//  resetn  in   1   asynchronous, active-high reset
//  Run     in   1   start an instruction (sampled in T0 only)
//  DIN     in   DW  instruction word (T0) / immediate (mvi T1)
//  IR      out  DW  instruction register
//  IRin    out  1   IR load strobe
//  Rin     out  8   register load enables
//  Rout    out  8   register bus drive (one-hot or zero)
//  DINout  out  1   DIN drives bus
//  Gout    out  1   G drives bus
//  Ain     out  1   load A
//  Gin     out  1   load G from adder
//  AddSub  out  1   0 = add, 1 = subtract
//  Done    out  1   final step of the instruction
//  Busy    out  1   not in T0
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          P_clock,
  input  logic          resetn,
  input  logic          Run,
  input  logic [DW-1:0] DIN,
  output logic [DW-1:0] IR,
  output logic          IRin,
  output logic [7:0]    Rin,
  output logic [7:0]    Rout,
  output logic          DINout,
  output logic          Gout,
  output logic          Ain,
  output logic          Gin,
  output logic          AddSub,
  output logic          Done,
  output logic          Busy
);

  state_t     state, state_n;
  logic [1:0] opc;
  logic [2:0] rx, ry;
  logic [7:0] x_oh, y_oh;
  logic       dec_en;

  assign opc    = opc_of(IR[7:0]);
  assign rx     = rx_of(IR[7:0]);
  assign ry     = ry_of(IR[7:0]);
  // Decoders stay silent in T0 so no register select can leak onto the bus.
  assign dec_en = (state != T0);

  reg_onehot_dec u_dec_x (
    .sel    (rx),
    .en     (dec_en),
    .onehot (x_oh)
  );

  reg_onehot_dec u_dec_y (
    .sel    (ry),
    .en     (dec_en),
    .onehot (y_oh)
  );

  always_ff @(posedge P_clock or posedge resetn) begin
    if (resetn) begin
      state <= T0;
      IR    <= '0;
    end else begin
      state <= state_n;
      if (IRin) IR <= DIN;
    end
  end

  always_comb begin
    state_n = state;
    Rin     = '0;
    Rout    = '0;
    DINout  = 1'b0;
    Gout    = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    Busy    = (state != T0);
    // Gated by reset so every output reads zero while reset is held.
    IRin    = (state == T0) && Run && !resetn;

    unique case (state)
      T0: begin
        if (Run) state_n = T1;
      end
      T1: begin
        unique case (opc)
          OP_MV: begin
            Rout    = y_oh;
            Rin     = x_oh;
            Done    = 1'b1;
            state_n = T0;
          end
          OP_MVI: begin
            DINout  = 1'b1;
            Rin     = x_oh;
            Done    = 1'b1;
            state_n = T0;
          end
          OP_ADD, OP_SUB: begin
            Rout    = x_oh;
            Ain     = 1'b1;
            state_n = T2;
          end
        endcase
      end
      T2: begin
        Rout    = y_oh;
        Gin     = 1'b1;
        AddSub  = (opc == OP_SUB);
        state_n = T3;
      end
      T3: begin
        Gout    = 1'b1;
        Rin     = x_oh;
        Done    = 1'b1;
        state_n = T0;
      end
    endcase
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm. A bench-owned datapath (R0-R7, A,
// G, adder) is driven by the DUT's control outputs; register contents are
// compared with an instruction-level model, and per-cycle control outputs
// are compared with step sequences derived from the instruction semantics.
module tb_proc_ctrl_fsm;

  logic       P_clock = 1'b0;
  logic       resetn;
  logic       Run;
  logic [7:0] DIN;
  logic [7:0] IR;
  logic       IRin;
  logic [7:0] Rin, Rout;
  logic       DINout, Gout, Ain, Gin, AddSub, Done, Busy;

  proc_ctrl_fsm #(.DW(8)) dut (
    .P_clock (P_clock),
    .resetn  (resetn),
    .Run     (Run),
    .DIN     (DIN),
    .IR      (IR),
    .IRin    (IRin),
    .Rin     (Rin),
    .Rout    (Rout),
    .DINout  (DINout),
    .Gout    (Gout),
    .Ain     (Ain),
    .Gin     (Gin),
    .AddSub  (AddSub),
    .Done    (Done),
    .Busy    (Busy)
  );

  always #5 P_clock = ~P_clock;

  typedef struct packed {
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       gout;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
    logic       busy;
    logic       irin;
  } exp_t;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Architectural model and bench datapath.
  logic [7:0] rf_ref [8];
  logic [7:0] dp_r   [8];
  logic [7:0] dp_a, dp_g;
  logic [7:0] ir_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] v;
    v = 8'h01;
    return v << i;
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // let the bench datapath react to the DUT's controls on the rising edge.
  task automatic cycle(input logic run_v, input logic [7:0] din_v, input exp_t e);
    logic [7:0] bus;
    int         nb;
    Run = run_v;
    DIN = din_v;
    @(negedge P_clock);
    chk("rin",  {24'd0, Rin},  {24'd0, e.rin});
    chk("rout", {24'd0, Rout}, {24'd0, e.rout});
    chk("ctl",  {24'd0, DINout, Gout, Ain, Gin, AddSub, Done, Busy, IRin},
                {24'd0, e.dinout, e.gout, e.ain, e.gin, e.addsub, e.done, e.busy, e.irin});
    chk("ir",   {24'd0, IR}, {24'd0, ir_exp});
    nb = $countones(Rout) + int'(DINout) + int'(Gout);
    chk("bus_excl", (nb <= 1) ? 32'd1 : 32'd0, 32'd1);
    bus = 8'h00;
    if (DINout) bus = DIN;
    else if (Gout) bus = dp_g;
    else for (int i = 0; i < 8; i++) if (Rout[i]) bus = dp_r[i];
    begin
      logic       ld_a, ld_g, sub;
      logic [7:0] ld_r;
      ld_a = Ain; ld_g = Gin; sub = AddSub; ld_r = Rin;
      @(posedge P_clock);
      if (ld_g) dp_g = sub ? dp_a - bus : dp_a + bus;
      if (ld_a) dp_a = bus;
      for (int i = 0; i < 8; i++) if (ld_r[i]) dp_r[i] = bus;
    end
    if (e.irin) ir_exp = din_v;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle(1'b0, 8'($urandom), exp_t'('0));
  endtask

  task automatic do_instr(input logic [7:0] ins, input logic [7:0] imm);
    logic [1:0] op;
    logic [2:0] x, y;
    exp_t       e;
    op = ins[7:6];
    x  = ins[5:3];
    y  = ins[2:0];
    e = '0; e.irin = 1'b1;
    cycle(1'b1, ins, e);
    case (op)
      2'b00: begin
        e = '0; e.busy = 1; e.rout = oh(y); e.rin = oh(x); e.done = 1;
        cycle(1'($urandom_range(0, 1)), 8'($urandom), e);
        rf_ref[x] = rf_ref[y];
      end
      2'b01: begin
        e = '0; e.busy = 1; e.dinout = 1; e.rin = oh(x); e.done = 1;
        cycle(1'($urandom_range(0, 1)), imm, e);
        rf_ref[x] = imm;
      end
      default: begin
        e = '0; e.busy = 1; e.rout = oh(x); e.ain = 1;
        cycle(1'($urandom_range(0, 1)), 8'($urandom), e);
        e = '0; e.busy = 1; e.rout = oh(y); e.gin = 1; e.addsub = (op == 2'b11);
        cycle(1'($urandom_range(0, 1)), 8'($urandom), e);
        e = '0; e.busy = 1; e.gout = 1; e.rin = oh(x); e.done = 1;
        cycle(1'($urandom_range(0, 1)), 8'($urandom), e);
        rf_ref[x] = (op == 2'b11) ? rf_ref[x] - rf_ref[y] : rf_ref[x] + rf_ref[y];
      end
    endcase
    chk("reg", {24'd0, dp_r[x]}, {24'd0, rf_ref[x]});
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      rf_ref[i] = 8'h00;
      dp_r[i]   = 8'h00;
    end
    dp_a = 8'h00; dp_g = 8'h00; ir_exp = 8'h00;
    Run = 1'b1; DIN = 8'h40; resetn = 1'b0;
    #1 resetn = 1'b1;
    #2;
    // Reset with Run high: everything reads zero.
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_irin", {31'd0, IRin}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_rin",  {24'd0, Rin},  32'd0);
    chk("rst_rout", {24'd0, Rout}, 32'd0);
    chk("rst_ir",   {24'd0, IR},   32'd0);
    @(negedge P_clock);
    resetn = 1'b0;
    Run = 1'b0;
    @(posedge P_clock);
    #1;

    // Directed program.
    do_instr(8'h40, 8'h5A);                 // mvi R0,#5A
    chk("r0_5a", {24'd0, dp_r[0]}, 32'h5A);
    do_instr(8'h08, 8'h00);                 // mv R1,R0
    chk("r1_5a", {24'd0, dp_r[1]}, 32'h5A);
    do_instr(8'h81, 8'h00);                 // add R0,R1
    chk("r0_b4", {24'd0, dp_r[0]}, 32'hB4);
    do_instr(8'hC0, 8'h00);                 // sub R0,R0
    chk("r0_00", {24'd0, dp_r[0]}, 32'h00);
    do_instr(8'h50, 8'h01);                 // mvi R2,#1
    do_instr(8'hC2, 8'h00);                 // sub R0,R2 -> wrap
    chk("r0_ff", {24'd0, dp_r[0]}, 32'hFF);
    do_instr(8'h1B, 8'h00);                 // mv R3,R3
    idle(3);

    // Random stream: mostly back-to-back, with occasional idle gaps.
    for (int n = 0; n < 300; n++) begin
      do_instr(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end

    // Reset in T2 of add R0,R1: no Rin pulse, IR cleared, back in T0.
    e = '0; e.irin = 1'b1;
    cycle(1'b1, 8'h81, e);
    e = '0; e.busy = 1; e.rout = 8'h01; e.ain = 1;
    cycle(1'b0, 8'h00, e);
    Run = 1'b1;
    #2 resetn = 1'b1;
    #1;
    chk("mid_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rin",  {24'd0, Rin},  32'd0);
    chk("mid_rout", {24'd0, Rout}, 32'd0);
    chk("mid_done", {31'd0, Done}, 32'd0);
    chk("mid_gin",  {31'd0, Gin},  32'd0);
    chk("mid_ir",   {24'd0, IR},   32'd0);
    ir_exp = 8'h00;
    @(negedge P_clock);
    resetn = 1'b0;
    Run = 1'b0;
    @(posedge P_clock);
    #1;
    idle(2);
    for (int i = 0; i < 8; i++) chk("post_rst_reg", {24'd0, dp_r[i]}, {24'd0, rf_ref[i]});
    do_instr(8'h81, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
